// File: rtl/atomrvcore_ifu_prefetch.sv
// Instruction fetch unit with prefetch buffer.
// Owns the fetch PC, issues word requests to instruction memory, buffers the
// returned words with their PCs in a small FIFO and presents them to decode.
// A redirect flushes the FIFO and turns every in-flight response into a
// stale one that is discarded when it arrives.
module atomrvcore_ifu_prefetch #(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 4,
   parameter int MAX_OUTS = 2,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            PCrst_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            instr_valid_o,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   input  logic            instr_ready_i,
   input  logic            br_en_i,
   input  logic            jal_en_i,
   input  logic            jalr_en_i,
   input  logic [XLEN-1:0] ctl_pc_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [XLEN-1:0] rs1_i,
   output logic [XLEN-1:0] link_o,
   output logic            misalign_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + 1;
   localparam int OW = $clog2(MAX_OUTS + 1);
   localparam int TW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
   localparam logic [SW-1:0] DEPTH_S   = SW'(DEPTH);
   localparam logic [OW-1:0] MAX_OUT_S = OW'(MAX_OUTS);
   localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_OUTS - 1);

   logic [XLEN-1:0] fetch_pc_reg;
   logic [XLEN-1:0] instr_mem [DEPTH];
   logic [XLEN-1:0] pc_mem [DEPTH];
   logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic [OW-1:0]   outs_reg, drop_reg;
   logic [XLEN-1:0] tag_mem [MAX_OUTS];
   logic [TW-1:0]   tag_wr_reg, tag_rd_reg;
   logic            misalign_reg;

   logic            redirect, issue, fire, resp, push, pop, head_valid;
   logic [XLEN-1:0] jalr_sum, target;
   logic [SW-1:0]   occupancy;

   // Redirect target: jalr has priority; branch and jal share the pc-relative form
   always_comb begin
      jalr_sum = rs1_i + imm_i;
      target   = ctl_pc_i + {imm_i[XLEN-2:0], 1'b0};
      if (jalr_en_i) begin
         target = jalr_sum & ~XLEN'(1);
      end
   end

   // Request/response/FIFO handshake decode; a redirect overrides issue and pop
   always_comb begin
      redirect   = br_en_i | jal_en_i | jalr_en_i;
      occupancy  = SW'(count_reg) + SW'(outs_reg);
      issue      = PCrst_i && (occupancy < DEPTH_S) && (outs_reg < MAX_OUT_S) && !redirect;
      fire       = issue && imem_gnt_i;
      resp       = imem_rvalid_i && (outs_reg != '0);
      push       = resp && (drop_reg == '0) && !redirect;
      head_valid = (count_reg != '0);
      pop        = head_valid && instr_ready_i && !redirect;
   end

   // Fetch PC: reload on redirect (word aligned), advance on every granted request
   always_ff @(posedge clk_i or negedge PCrst_i) begin
      if (!PCrst_i) begin
         fetch_pc_reg <= RESET_PC;
      end else if (redirect) begin
         fetch_pc_reg <= {target[XLEN-1:2], 2'b00};
      end else if (fire) begin
         fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
      end
   end

   // Outstanding and stale-response counters; on redirect everything still in flight is stale
   always_ff @(posedge clk_i or negedge PCrst_i) begin
      if (!PCrst_i) begin
         outs_reg <= '0;
         drop_reg <= '0;
      end else begin
         outs_reg <= outs_reg + OW'(fire) - OW'(resp);
         if (redirect) begin
            drop_reg <= outs_reg - OW'(resp);
         end else if (resp && drop_reg != '0) begin
            drop_reg <= drop_reg - OW'(1);
         end
      end
   end

   // Tag queue pointers: one tag per outstanding request, consumed in order
   always_ff @(posedge clk_i or negedge PCrst_i) begin
      if (!PCrst_i) begin
         tag_wr_reg <= '0;
         tag_rd_reg <= '0;
      end else begin
         if (fire) tag_wr_reg <= (tag_wr_reg == TAG_LAST) ? '0 : tag_wr_reg + TW'(1);
         if (resp) tag_rd_reg <= (tag_rd_reg == TAG_LAST) ? '0 : tag_rd_reg + TW'(1);
      end
   end

   // Tag storage: remember the PC of each granted request
   always_ff @(posedge clk_i) begin
      if (fire) tag_mem[tag_wr_reg] <= fetch_pc_reg;
   end

   // FIFO pointers and occupancy; a redirect empties the buffer
   always_ff @(posedge clk_i or negedge PCrst_i) begin
      if (!PCrst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (redirect) begin
         rd_ptr_reg <= wr_ptr_reg;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         count_reg <= count_reg + CW'(push) - CW'(pop);
      end
   end

   // FIFO storage, one write port per entry
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture the returned word with the PC of the request it answers
      always_ff @(posedge clk_i) begin
         if (push && wr_ptr_reg == PW'(gi)) begin
            instr_mem[gi] <= imem_rdata_i;
            pc_mem[gi]    <= tag_mem[tag_rd_reg];
         end
      end
   end

   // Misalignment flag: single-cycle pulse after a redirect to a non-word target
   always_ff @(posedge clk_i or negedge PCrst_i) begin
      if (!PCrst_i) begin
         misalign_reg <= 1'b0;
      end else begin
         misalign_reg <= redirect && (target[1:0] != 2'b00);
      end
   end

   assign imem_req_o    = issue;
   assign imem_addr_o   = fetch_pc_reg;
   assign instr_valid_o = head_valid;
   assign instr_o       = head_valid ? instr_mem[rd_ptr_reg] : '0;
   assign instr_pc_o    = head_valid ? pc_mem[rd_ptr_reg] : '0;
   assign link_o        = ctl_pc_i + XLEN'(4);
   assign misalign_o    = misalign_reg;

endmodule

// File: tb/tb_atomrvcore_ifu_prefetch.sv
// Randomized bench for the fetch unit. The reference tracks granted requests
// as an ordered list (stale after a redirect) and the decode-visible stream as
// a queue of {instr, pc}; every cycle the DUT outputs are compared with them.
module tb_atomrvcore_ifu_prefetch;
   localparam int XLEN     = 32;
   localparam int DEPTH    = 4;
   localparam int MAX_OUTS = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        PCrst_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i;
   logic        br_en_i, jal_en_i, jalr_en_i;
   logic [31:0] ctl_pc_i, imm_i, rs1_i;
   logic [31:0] link_o;
   logic        misalign_o;

   always #5 clk = ~clk;

   atomrvcore_ifu_prefetch #(
      .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTS(MAX_OUTS), .RESET_PC(RESET_PC)
   ) u_dut (
      .clk_i(clk), .PCrst_i(PCrst_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
      .instr_ready_i(instr_ready_i),
      .br_en_i(br_en_i), .jal_en_i(jal_en_i), .jalr_en_i(jalr_en_i),
      .ctl_pc_i(ctl_pc_i), .imm_i(imm_i), .rs1_i(rs1_i),
      .link_o(link_o), .misalign_o(misalign_o)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic        stale;
      int          due;
   } req_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } word_t;

   req_t        inflight[$];
   word_t       fifo_q[$];
   logic [31:0] model_pc;
   bit          exp_mis;
   int          cyc;
   int          n_checks;
   int          n_fail;
   int          n_pops;

   // Memory contents as a function of address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Redirect target from the architectural rules
   function automatic logic [31:0] redirect_target(input bit is_jalr, input logic [31:0] ctl,
                                                   input logic [31:0] imm, input logic [31:0] rs1);
      logic [31:0] s;
      if (is_jalr) begin
         s = rs1 + imm;
         return s - (s % 2);
      end
      return ctl + imm * 2;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_model();
      inflight.delete();
      fifo_q.delete();
      model_pc = RESET_PC;
      exp_mis  = 1'b0;
   endtask

   task automatic idle_inputs();
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      instr_ready_i = 1'b0;
      br_en_i       = 1'b0;
      jal_en_i      = 1'b0;
      jalr_en_i     = 1'b0;
      ctl_pc_i      = '0;
      imm_i         = '0;
      rs1_i         = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req"},      imem_req_o,    1'b0);
      check_eq({tag, "_addr"},     imem_addr_o,   RESET_PC);
      check_eq({tag, "_valid"},    instr_valid_o, 1'b0);
      check_eq({tag, "_instr"},    instr_o,       32'h0);
      check_eq({tag, "_pc"},       instr_pc_o,    32'h0);
      check_eq({tag, "_misalign"}, misalign_o,    1'b0);
   endtask

   // One clock: drive inputs at negedge, compare, then advance the reference
   task automatic step(input bit allow_redirect, input bit stall);
      bit          redir, mreq;
      int          kind;
      logic [31:0] tgt;
      req_t        r;
      @(negedge clk);
      imem_gnt_i    = ($urandom_range(0, 3) != 0);
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
      if (inflight.size() != 0 && inflight[0].due <= cyc && $urandom_range(0, 3) != 0) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = mem_word(inflight[0].addr);
      end else if (inflight.size() == 0 && $urandom_range(0, 31) == 0) begin
         imem_rvalid_i = 1'b1;
      end
      instr_ready_i = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      br_en_i   = 1'b0;
      jal_en_i  = 1'b0;
      jalr_en_i = 1'b0;
      ctl_pc_i  = $urandom;
      imm_i     = $urandom;
      rs1_i     = $urandom;
      if (allow_redirect && $urandom_range(0, 15) == 0) begin
         kind = $urandom_range(0, 6);
         case (kind)
            0: br_en_i = 1'b1;
            1: jal_en_i = 1'b1;
            2: jalr_en_i = 1'b1;
            3: begin br_en_i = 1'b1; jalr_en_i = 1'b1; end
            4: begin jalr_en_i = 1'b1; rs1_i = 32'hFFFF_FFE0 + $urandom_range(0, 15); imm_i = $urandom_range(0, 8); end
            5: begin jal_en_i = 1'b1; ctl_pc_i = 32'h10; imm_i = 32'h8; end
            default: begin jalr_en_i = 1'b1; rs1_i = 32'h103; imm_i = 32'h0; end
         endcase
      end
      #1;
      redir = br_en_i || jal_en_i || jalr_en_i;
      tgt   = redirect_target(jalr_en_i, ctl_pc_i, imm_i, rs1_i);
      mreq  = (fifo_q.size() + inflight.size() < DEPTH) && (inflight.size() < MAX_OUTS) && !redir;

      check_eq("req", imem_req_o, mreq);
      if (mreq) check_eq("addr", imem_addr_o, model_pc);
      check_eq("valid", instr_valid_o, fifo_q.size() != 0);
      if (fifo_q.size() != 0) begin
         check_eq("instr", instr_o, fifo_q[0].instr);
         check_eq("instr_pc", instr_pc_o, fifo_q[0].pc);
      end
      check_eq("misalign", misalign_o, exp_mis);
      check_eq("link", link_o, ctl_pc_i + 32'd4);

      if (fifo_q.size() != 0 && instr_ready_i && !redir) begin
         $display("[%0d] pop pc=%h instr=%h", cyc, fifo_q[0].pc, fifo_q[0].instr);
         void'(fifo_q.pop_front());
         n_pops++;
      end
      if (imem_rvalid_i && inflight.size() != 0) begin
         r = inflight.pop_front();
         if (!r.stale && !redir) fifo_q.push_back('{instr: mem_word(r.addr), pc: r.addr});
      end
      if (redir) begin
         $display("[%0d] redirect br=%0b jal=%0b jalr=%0b target=%h", cyc, br_en_i, jal_en_i, jalr_en_i, tgt);
         fifo_q.delete();
         foreach (inflight[i]) inflight[i].stale = 1'b1;
         model_pc = tgt - (tgt % 4);
         exp_mis  = (tgt % 4) != 0;
      end else begin
         exp_mis = 1'b0;
      end
      if (mreq && imem_gnt_i) begin
         inflight.push_back('{addr: model_pc, stale: 1'b0, due: cyc + $urandom_range(1, 3)});
         model_pc = model_pc + 32'd4;
      end
      cyc++;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      n_pops   = 0;
      cyc      = 0;
      PCrst_i  = 1'b0;
      idle_inputs();
      clear_model();
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check_reset_outputs("reset");
      PCrst_i = 1'b1;

      for (int i = 0; i < 700; i++) begin
         step((i % 100) >= 20, (i % 100) >= 60 && (i % 100) < 72);
      end

      // Asynchronous reset in the middle of traffic
      @(posedge clk);
      #3;
      PCrst_i = 1'b0;
      idle_inputs();
      #1;
      check_reset_outputs("async_reset");
      clear_model();
      repeat (2) @(posedge clk);
      @(negedge clk);
      PCrst_i = 1'b1;

      for (int i = 0; i < 700; i++) begin
         step((i % 100) >= 10, (i % 100) >= 40 && (i % 100) < 52);
      end

      check_eq("progress", n_pops > 200, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
